// File: rtl/dmem_arb.sv
// ============================================================================
// Module   : dmem_arb
// Brief    : Two-port (core/host) data-memory arbiter: round-robin with host
//            burst lock, one-cycle read return and optional statistics
//            counters built when DMEM_ARB_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arb #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdat,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdat,
  input  logic          h_req,
  input  logic          h_we,
  input  logic          h_lock,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdat,
  output logic          h_gnt,
  output logic          h_rvalid,
  output logic [DW-1:0] h_rdat,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdat,
  output logic          mem_wr_en,
  output logic          mem_ren,
  input  logic [DW-1:0] mem_rdat,
  output logic [15:0]   stat_c_gnt,
  output logic [15:0]   stat_h_gnt,
  output logic [15:0]   stat_c_stall
);

  localparam int            CW        = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] burst, burst_nxt;
  logic          rr_core, rr_core_nxt;  // 1: core wins a tie
  logic          tie_core;
  logic          gc, gh;
  logic          c_rd_pend, h_rd_pend;
  logic [DW-1:0] c_hold, h_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      burst   <= '0;
      rr_core <= 1'b1;
    end else begin
      state   <= state_nxt;
      burst   <= burst_nxt;
      rr_core <= rr_core_nxt;
    end
  end

  always_comb begin
    gc          = 1'b0;
    gh          = 1'b0;
    tie_core    = rr_core;
    state_nxt   = state;
    burst_nxt   = burst;
    rr_core_nxt = rr_core;

    // Grants are gated by reset so outputs fall to zero immediately.
    if (rst_n) begin
      if (state == ST_LOCK && h_req && h_lock) begin
        if (c_req && burst == BURST_MAX) gc = 1'b1;
        else                             gh = 1'b1;
      end else begin
        // Leaving a burst falls back to round-robin with core favoured.
        if (state == ST_LOCK) tie_core = 1'b1;
        if (c_req && (!h_req || tie_core)) gc = 1'b1;
        else if (h_req)                    gh = 1'b1;
      end
    end

    if (gc)      rr_core_nxt = 1'b0;
    else if (gh) rr_core_nxt = 1'b1;

    if (gh && h_lock) begin
      state_nxt = ST_LOCK;
      if (state == ST_IDLE)        burst_nxt = CW'(1);
      else if (burst != BURST_MAX) burst_nxt = burst + CW'(1);
    end else begin
      state_nxt = ST_IDLE;
      burst_nxt = '0;
    end
  end

  assign c_gnt     = gc;
  assign h_gnt     = gh;
  assign mem_addr  = gc ? c_addr : (gh ? h_addr : '0);
  assign mem_wdat  = gc ? c_wdat : (gh ? h_wdat : '0);
  assign mem_wr_en = (gc & c_we) | (gh & h_we);
  assign mem_ren   = (gc & ~c_we) | (gh & ~h_we);

  // Per-port read-owner tags steer the returning data to its issuer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_rd_pend <= 1'b0;
      h_rd_pend <= 1'b0;
      c_hold    <= '0;
      h_hold    <= '0;
    end else begin
      c_rd_pend <= gc & ~c_we;
      h_rd_pend <= gh & ~h_we;
      if (c_rd_pend) c_hold <= mem_rdat;
      if (h_rd_pend) h_hold <= mem_rdat;
    end
  end

  assign c_rvalid = c_rd_pend;
  assign h_rvalid = h_rd_pend;
  assign c_rdat   = c_rd_pend ? mem_rdat : c_hold;
  assign h_rdat   = h_rd_pend ? mem_rdat : h_hold;

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_c_gnt   <= '0;
      stat_h_gnt   <= '0;
      stat_c_stall <= '0;
    end else begin
      if (gc && stat_c_gnt != 16'hFFFF)                stat_c_gnt   <= stat_c_gnt + 16'd1;
      if (gh && stat_h_gnt != 16'hFFFF)                stat_h_gnt   <= stat_h_gnt + 16'd1;
      if (c_req && !gc && stat_c_stall != 16'hFFFF)    stat_c_stall <= stat_c_stall + 16'd1;
    end
  end
`else
  assign stat_c_gnt   = '0;
  assign stat_h_gnt   = '0;
  assign stat_c_stall = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_arb.sv
// ============================================================================
// Module   : tb_dmem_arb
// Brief    : Self-checking bench for dmem_arb against a cycle-level model of
//            the arbitration, read-return and statistics rules.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arb;

  localparam int MAX_BURST = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req, c_we, h_req, h_we, h_lock;
  logic [7:0]  c_addr, c_wdat, h_addr, h_wdat;
  logic        c_gnt, c_rvalid, h_gnt, h_rvalid, mem_wr_en, mem_ren;
  logic [7:0]  c_rdat, h_rdat, mem_addr, mem_wdat;
  logic [7:0]  mem_rdat = 8'h00;
  logic [15:0] stat_c_gnt, stat_h_gnt, stat_c_stall;

  dmem_arb #(.AW(8), .DW(8), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdat(c_wdat),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdat(c_rdat),
    .h_req(h_req), .h_we(h_we), .h_lock(h_lock), .h_addr(h_addr), .h_wdat(h_wdat),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdat(h_rdat),
    .mem_addr(mem_addr), .mem_wdat(mem_wdat), .mem_wr_en(mem_wr_en), .mem_ren(mem_ren),
    .mem_rdat(mem_rdat),
    .stat_c_gnt(stat_c_gnt), .stat_h_gnt(stat_h_gnt), .stat_c_stall(stat_c_stall)
  );

  always #5 clk = ~clk;

  // Environment memory; random bus data when no read was issued.
  logic [7:0] tbmem [256];
  bit         mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) tbmem[i] = 8'(i * 37 + 11);
      mem_init = 1'b1;
    end
    mem_rdat <= mem_ren ? tbmem[mem_addr] : 8'($urandom);
    if (mem_wr_en) tbmem[mem_addr] = mem_wdat;
  end

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [85:0] obs, exp_v;

  // Reference model state
  logic [7:0] refmem [256];
  bit         m_lock, m_fav_core, m_rv_c, m_rv_h, p_gc, p_gh;
  int         m_cnt, m_sc, m_sh, m_ss;
  logic [7:0] m_dat_c, m_dat_h, m_hold_c, m_hold_h;

  task automatic model_reset();
    m_lock = 0; m_cnt = 0; m_fav_core = 1;
    m_rv_c = 0; m_rv_h = 0; m_hold_c = 0; m_hold_h = 0;
    m_dat_c = 0; m_dat_h = 0; m_sc = 0; m_sh = 0; m_ss = 0;
  endtask

  task automatic model_predict();
    bit          core_first;
    logic [7:0]  ma, mw;
    logic [47:0] st;
    p_gc = 0; p_gh = 0;
    if (m_lock && h_req && h_lock) begin
      if (c_req && m_cnt == MAX_BURST) p_gc = 1; else p_gh = 1;
    end else begin
      core_first = m_lock || m_fav_core;
      if (c_req && (!h_req || core_first)) p_gc = 1;
      else if (h_req) p_gh = 1;
    end
    ma = p_gc ? c_addr : (p_gh ? h_addr : 8'h00);
    mw = p_gc ? c_wdat : (p_gh ? h_wdat : 8'h00);
`ifdef DMEM_ARB_STATS_EN
    st = {16'(m_sc), 16'(m_sh), 16'(m_ss)};
`else
    st = '0;
`endif
    exp_v = {p_gc, m_rv_c, (m_rv_c ? m_dat_c : m_hold_c),
             p_gh, m_rv_h, (m_rv_h ? m_dat_h : m_hold_h),
             ma, mw, ((p_gc && c_we) || (p_gh && h_we)),
             ((p_gc && !c_we) || (p_gh && !h_we)), st};
  endtask

  task automatic model_commit();
    if (m_rv_c) m_hold_c = m_dat_c;
    if (m_rv_h) m_hold_h = m_dat_h;
    m_rv_c = p_gc && !c_we;
    m_rv_h = p_gh && !h_we;
    if (m_rv_c) m_dat_c = refmem[c_addr];
    if (m_rv_h) m_dat_h = refmem[h_addr];
    if (p_gc && c_we) refmem[c_addr] = c_wdat;
    if (p_gh && h_we) refmem[h_addr] = h_wdat;
    if (p_gc && m_sc < 65535) m_sc++;
    if (p_gh && m_sh < 65535) m_sh++;
    if (c_req && !p_gc && m_ss < 65535) m_ss++;
    if (p_gh && h_lock) begin
      m_cnt  = m_lock ? ((m_cnt < MAX_BURST) ? m_cnt + 1 : m_cnt) : 1;
      m_lock = 1;
    end else begin
      m_lock = 0; m_cnt = 0;
    end
    if (p_gc) m_fav_core = 0; else if (p_gh) m_fav_core = 1;
  endtask

  // Called at posedge+1; samples settled outputs on the falling edge.
  task automatic cycle_begin();
    @(negedge clk);
    obs = {c_gnt, c_rvalid, c_rdat, h_gnt, h_rvalid, h_rdat,
           mem_addr, mem_wdat, mem_wr_en, mem_ren, stat_c_gnt, stat_h_gnt, stat_c_stall};
    model_predict();
  endtask

  task automatic cycle_end();
    @(posedge clk);
    model_commit();
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    c_req = 0; c_we = 0; c_addr = 0; c_wdat = 0;
    h_req = 0; h_we = 0; h_lock = 0; h_addr = 0; h_wdat = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    c_req = 1; h_req = 1; h_lock = 1; c_addr = 8'h44; h_addr = 8'h55;
    for (int i = 0; i < 256; i++) refmem[i] = 8'(i * 37 + 11);
    repeat (2) @(posedge clk);
    #1;
    obs = {c_gnt, c_rvalid, c_rdat, h_gnt, h_rvalid, h_rdat,
           mem_addr, mem_wdat, mem_wr_en, mem_ren, stat_c_gnt, stat_h_gnt, stat_c_stall};
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL reset_outputs obs=%h exp=0", obs);
    end
    rst_n = 1;
    model_reset();
    idle_inputs();
  endtask

  task automatic test_dual_read();
    c_req = 1; c_we = 0; c_addr = 8'h10;
    h_req = 1; h_we = 0; h_addr = 8'h20; h_lock = 0;
    for (int k = 0; k < 3; k++) begin
      cycle_begin();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL dual_read cyc=%0d obs=%h exp=%h", cyc, obs, exp_v);
      end
      if (k == 0) begin
        checks++;
        if ({c_gnt, h_gnt} !== 2'b10) begin
          failures++;
          $display("FAIL dual_first_gnt obs=%b exp=10", {c_gnt, h_gnt});
        end
      end
      if (k == 1) begin
        checks++;
        if ({h_gnt, c_rvalid, c_rdat} !== {2'b11, refmem[8'h10]}) begin
          failures++;
          $display("FAIL dual_core_ret obs=%h exp=%h", {h_gnt, c_rvalid, c_rdat}, {2'b11, refmem[8'h10]});
        end
      end
      if (k == 2) begin
        checks++;
        if ({c_rvalid, h_rvalid, h_rdat} !== {2'b01, refmem[8'h20]}) begin
          failures++;
          $display("FAIL dual_host_ret obs=%h exp=%h", {c_rvalid, h_rvalid, h_rdat}, {2'b01, refmem[8'h20]});
        end
      end
      cycle_end();
      if (k == 0) c_req = 0;
      if (k == 1) h_req = 0;
    end
  endtask

  task automatic test_write_read();
    idle_inputs();
    h_req = 1; h_we = 1; h_addr = 8'h30; h_wdat = 8'h5A;
    for (int k = 0; k < 3; k++) begin
      cycle_begin();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL write_read cyc=%0d obs=%h exp=%h", cyc, obs, exp_v);
      end
      if (k == 0) begin
        checks++;
        if ({mem_wr_en, mem_ren} !== 2'b10) begin
          failures++;
          $display("FAIL host_write_strobe obs=%b exp=10", {mem_wr_en, mem_ren});
        end
      end
      if (k == 2) begin
        checks++;
        if ({c_rvalid, c_rdat} !== {1'b1, 8'h5A}) begin
          failures++;
          $display("FAIL core_read_back obs=%h exp=15a", {c_rvalid, c_rdat});
        end
      end
      cycle_end();
      idle_inputs();
      if (k == 0) begin c_req = 1; c_we = 0; c_addr = 8'h30; end
    end
  endtask

  task automatic test_lock_release();
    int hcnt = 0;
    bit done = 0;
`ifdef DMEM_ARB_STATS_EN
    int b_sc, b_sh, b_ss;
`endif
    idle_inputs();
    c_req = 1; c_we = 1; c_addr = 8'($urandom); c_wdat = 8'($urandom);
    cycle_begin();
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL lock_pre cyc=%0d obs=%h exp=%h", cyc, obs, exp_v);
    end
    cycle_end();
`ifdef DMEM_ARB_STATS_EN
    b_sc = m_sc; b_sh = m_sh; b_ss = m_ss;
`endif
    c_we = 0; c_addr = 8'($urandom);
    h_req = 1; h_lock = 1; h_we = 1;
    for (int n = 0; n < 40 && !done; n++) begin
      h_addr = 8'($urandom); h_wdat = 8'($urandom);
      cycle_begin();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL lock_release cyc=%0d obs=%h exp=%h", cyc, obs, exp_v);
      end
      if (c_gnt) done = 1;
      else if (h_gnt) hcnt++;
      cycle_end();
    end
    idle_inputs();
    checks++;
    if (!done || hcnt != MAX_BURST) begin
      failures++;
      $display("FAIL lock_burst_len obs=%0d/%0d exp=%0d/1", hcnt, done, MAX_BURST);
    end
    cycle_begin();
`ifdef DMEM_ARB_STATS_EN
    checks++;
    if ({stat_c_gnt, stat_h_gnt, stat_c_stall} !==
        {16'(b_sc + 1), 16'(b_sh + MAX_BURST), 16'(b_ss + MAX_BURST)}) begin
      failures++;
      $display("FAIL lock_stats obs=%h exp=%h", {stat_c_gnt, stat_h_gnt, stat_c_stall},
               {16'(b_sc + 1), 16'(b_sh + MAX_BURST), 16'(b_ss + MAX_BURST)});
    end
`else
    checks++;
    if ({stat_c_gnt, stat_h_gnt, stat_c_stall} !== 48'h0) begin
      failures++;
      $display("FAIL stats_tied obs=%h exp=0", {stat_c_gnt, stat_h_gnt, stat_c_stall});
    end
`endif
    cycle_end();
  endtask

  task automatic test_lock_hold();
    int hcnt = 0;
    idle_inputs();
    h_req = 1; h_lock = 1; h_we = 0;
    for (int n = 0; n < 40; n++) begin
      h_addr = 8'($urandom);
      cycle_begin();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL lock_hold cyc=%0d obs=%h exp=%h", cyc, obs, exp_v);
      end
      if (h_gnt) hcnt++;
      cycle_end();
    end
    idle_inputs();
    checks++;
    if (hcnt != 40) begin
      failures++;
      $display("FAIL lock_hold_count obs=%0d exp=40", hcnt);
    end
  endtask

  task automatic test_reset_inflight();
    idle_inputs();
    c_req = 1; c_we = 0; c_addr = 8'($urandom);
    cycle_begin();
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL inflight_issue cyc=%0d obs=%h exp=%h", cyc, obs, exp_v);
    end
    cycle_end();
    rst_n = 0;
    h_req = 1;
    #1;
    obs = {c_gnt, c_rvalid, c_rdat, h_gnt, h_rvalid, h_rdat,
           mem_addr, mem_wdat, mem_wr_en, mem_ren, stat_c_gnt, stat_h_gnt, stat_c_stall};
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL inflight_reset obs=%h exp=0", obs);
    end
    idle_inputs();
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
    cycle_begin();
    checks++;
    if (obs !== exp_v || c_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL inflight_discard obs=%h exp=%h", obs, exp_v);
    end
    cycle_end();
  endtask

  task automatic test_random();
    idle_inputs();
    for (int n = 0; n < 400; n++) begin
      cycle_begin();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL random cyc=%0d obs=%h exp=%h", cyc, obs, exp_v);
      end
      cycle_end();
      // A pending, ungranted request holds its inputs.
      if (!(c_req && !p_gc)) begin
        c_req  = ($urandom_range(0, 99) < 50);
        c_we   = 1'($urandom);
        c_addr = 8'($urandom_range(0, 15));
        c_wdat = 8'($urandom);
      end
      if (!(h_req && !p_gh)) begin
        h_lock = (h_lock && p_gh) ? ($urandom_range(0, 99) < 92) : ($urandom_range(0, 99) < 40);
        h_req  = h_lock || ($urandom_range(0, 99) < 50);
        h_we   = 1'($urandom);
        h_addr = 8'($urandom_range(0, 15));
        h_wdat = 8'($urandom);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_dual_read();
    test_write_read();
    test_lock_release();
    test_lock_hold();
    test_reset_inflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_arb.md
DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 Parameter AW, default 8, address width.
REQ-002 Parameter DW, default 8, data width.
REQ-003 Parameter MAX_BURST, default 16, max consecutive locked host grants while core waits.
REQ-004 Clk  input  1  single clock, all state on rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 c_req, c_we  input  1 each  core access request / write-enable.
REQ-007 c_addr, c_wdat  input  AW / DW  core address / write data.
REQ-008 c_gnt, c_rvalid  output  1 each  core grant / read-data-valid.
REQ-009 c_rdat  output  DW  core read data.
REQ-010 h_req, h_we, h_lock  input  1 each  host request / write-enable / burst-lock.
REQ-011 h_addr, h_wdat  input  AW / DW  host address / write data.
REQ-012 h_gnt, h_rvalid  output  1 each  host grant / read-data-valid.
REQ-013 h_rdat  output  DW  host read data.
REQ-014 mem_addr, mem_wdat  output  AW / DW  memory address / write data.
REQ-015 mem_wr_en, mem_ren  output  1 each  memory write / read strobe.
REQ-016 mem_rdat  input  DW  memory read data, valid one cycle after mem_ren.
REQ-017 stat_c_gnt, stat_h_gnt, stat_c_stall  output  16 each  statistics counters.

Function
REQ-018 Arbiter SHALL issue at most one memory command per cycle; gnt is combinational, same cycle as the command.
REQ-019 Granted port's addr/wdat SHALL drive mem_addr/mem_wdat; mem_wr_en=we, mem_ren=~we; with no grant all mem outputs SHALL be 0.
REQ-020 States: IDLE (round-robin) and LOCK (host burst); both SHALL be encoded in a state register.
REQ-021 IDLE, one requester: that requester SHALL be granted.
REQ-022 IDLE, both requesting: port not granted most recently SHALL win (rr pointer, updated on every grant).
REQ-023 IDLE -> LOCK when host granted with h_lock=1; burst counter SHALL load 1.
REQ-024 LOCK: h_req=1 and h_lock=1 SHALL grant host each cycle and increment burst counter, saturating at MAX_BURST.
REQ-025 LOCK -> IDLE when h_lock=0 or h_req=0; that cycle SHALL be arbitrated as IDLE with rr favouring core.
REQ-026 LOCK with c_req=1 and counter=MAX_BURST: core SHALL be granted that cycle, state -> IDLE, counter cleared.
REQ-027 LOCK with c_req=0: counter reaching MAX_BURST SHALL NOT release the lock.
REQ-028 Read latency: rvalid SHALL pulse exactly one cycle after the granted read, on the issuing port only, with rdat=mem_rdat; rdat SHALL hold last value otherwise.
REQ-029 Back-to-back reads from alternating ports SHALL each return to the correct owner (registered read-owner tag).
REQ-030 Writes SHALL produce no rvalid.
REQ-031 A request not granted SHALL keep its inputs stable until gnt; arbiter need not check this.

Reset
REQ-032 Reset low SHALL immediately force: state IDLE, rr favouring core, burst counter 0, gnt/rvalid 0, rdat 0, statistics 0.
REQ-033 A read in flight at reset SHALL be discarded; no rvalid after release.
REQ-034 First edge after release SHALL arbitrate normally.

Configuration
REQ-035 Macro DMEM_ARB_STATS_EN defined: stat_c_gnt/stat_h_gnt count grants per port, stat_c_stall counts cycles with c_req=1 and c_gnt=0; all saturate at 0xFFFF.
REQ-036 DMEM_ARB_STATS_EN undefined: counters not built, stat outputs tied to 0; arbitration identical.

Verification
REQ-037 Both request reads same cycle after reset, c_addr=0x10, h_addr=0x20 -> core granted first, host next cycle; c_rvalid then h_rvalid with correct data.
REQ-038 Host write 0x5A to 0x30, then core read 0x30 -> mem_wr_en one cycle, core rdat=0x5A one cycle after its grant.
REQ-039 Host h_lock=1 continuous, core requesting from cycle 0 -> 16 host grants, then core grant, state IDLE.
REQ-040 Host locked, no core request for 40 cycles -> 40 consecutive host grants, no release.
REQ-041 Reset asserted cycle after a granted read -> no rvalid, all outputs 0, stats 0.
REQ-042 STATS_EN defined, 16-grant lock scenario -> stat_c_stall=16, stat_h_gnt=16, stat_c_gnt=1.
